// File: rtl/ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle MIPS controller and its datapath.
// The controller side is the master; the datapath/next-PC side is the slave.
interface ctrl_fsm_if;
  logic [31:0] instr;
  logic        zero;
  logic        pc_write;
  logic        Branch;
  logic        Jump;
  logic [15:0] immediate_data;
  logic [25:0] jumpAdd;
  logic        RegDst;
  logic        ALUSrc;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  ALUOp;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  instr, zero,
    output pc_write, Branch, Jump, immediate_data, jumpAdd,
           RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           ALUOp, illegal, state, instr_count
  );

  modport slave (
    output instr, zero,
    input  pc_write, Branch, Jump, immediate_data, jumpAdd,
           RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           ALUOp, illegal, state, instr_count
  );
endinterface

// File: rtl/ctrl_fsm.sv
// Multi-cycle L&S MIPS control unit: latches the instruction in FETCH, sequences
// DECODE/EXEC/MEM/WB as a Moore machine and counts retired instructions.
module ctrl_fsm (
  input logic       clk,
  input logic       reset,
  ctrl_fsm_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] ir;
  logic [31:0] count;
  logic [5:0]  opcode;
  logic        retire;

  assign opcode = ir[31:26];

  // Every output depends only on the current state and the latched IR.
  always_comb begin
    state_d      = FETCH;
    retire       = 1'b0;
    bus.pc_write = 1'b0;
    bus.Branch   = 1'b0;
    bus.Jump     = 1'b0;
    bus.RegDst   = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.ALUOp    = 2'b00;
    bus.illegal  = 1'b0;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_J: begin
            bus.Jump     = 1'b1;
            bus.pc_write = 1'b1;
            retire       = 1'b1;
          end
          OP_BEQ, OP_RTYPE, OP_ADDI, OP_LW, OP_SW: state_d = EXEC;
          default: begin
            bus.illegal  = 1'b1;
            bus.pc_write = 1'b1;
          end
        endcase
      end
      EXEC: begin
        case (opcode)
          // zero is qualified by the next-PC unit, so the pulse is unconditional
          OP_BEQ: begin
            bus.ALUOp    = 2'b01;
            bus.Branch   = 1'b1;
            bus.pc_write = 1'b1;
            retire       = 1'b1;
          end
          OP_RTYPE: begin
            bus.ALUOp  = 2'b10;
            bus.RegDst = 1'b1;
            state_d    = WB;
          end
          OP_ADDI: begin
            bus.ALUSrc = 1'b1;
            state_d    = WB;
          end
          default: begin
            bus.ALUSrc = 1'b1;
            state_d    = MEM;
          end
        endcase
      end
      MEM: begin
        bus.ALUSrc = 1'b1;
        if (opcode == OP_SW) begin
          bus.MemWrite = 1'b1;
          bus.pc_write = 1'b1;
          retire       = 1'b1;
        end else begin
          bus.MemRead = 1'b1;
          state_d     = WB;
        end
      end
      WB: begin
        bus.RegWrite = 1'b1;
        bus.pc_write = 1'b1;
        retire       = 1'b1;
        bus.MemtoReg = (opcode == OP_LW);
        bus.ALUSrc   = (opcode == OP_ADDI);
        if (opcode == OP_RTYPE) begin
          bus.RegDst = 1'b1;
          bus.ALUOp  = 2'b10;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ir      <= 32'd0;
      count   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH)
        ir <= bus.instr;
      if (retire)
        count <= count + 32'd1;
    end
  end

  assign bus.state          = state_q;
  assign bus.immediate_data = ir[15:0];
  assign bus.jumpAdd        = ir[25:0];
  assign bus.instr_count    = count;
endmodule
